// File: rtl/ad9866_pkg.sv
// ad9866_pkg -- shared definitions for the AD9866 command queue.
//   state_t    : sequencer states
//   GAIN_ADDR  : AD9866 RX PGA gain register address
//   GAIN_PREFIX: control bits placed above the 6-bit gain code
//   TIMEOUT    : clk cycles allowed for the SPI engine to assert its enable
//   CMD_W      : width of a queued command {rw, addr[4:0], data[7:0]}
//   pack_word  : builds the 16-bit instruction+data word for the SPI engine
package ad9866_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_GAP
    } state_t;

    localparam logic [4:0]  GAIN_ADDR   = 5'h0A;
    localparam logic [1:0]  GAIN_PREFIX = 2'b01;
    localparam int unsigned TIMEOUT     = 15;
    localparam int unsigned CMD_W       = 14;

    // Read words carry no data byte; the engine shifts readback into that slot.
    function automatic logic [15:0] pack_word(input logic       rw,
                                              input logic [4:0] addr,
                                              input logic [7:0] data);
        return {rw, 2'b00, addr, (rw ? 8'h00 : data)};
    endfunction

endpackage

// File: rtl/ad9866_cmdfifo.sv
// ad9866_cmdfifo -- synchronous command FIFO.
//   clk, reset : clock, asynchronous active-high reset
//   push, din  : write strobe and 14-bit entry {rw, addr, data}
//   pop        : read strobe; dout always presents the head entry
//   full, empty: occupancy flags
// Pushes while full and pops while empty are ignored; pointers wrap modulo DEPTH.
module ad9866_cmdfifo
    import ad9866_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [CMD_W-1:0] din,
    input  logic             pop,
    output logic [CMD_W-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ad9866_cmdq.sv
// ad9866_cmdq -- queues host register commands and RX gain updates for an
// external AD9866 SPI engine, one transaction at a time.
//   clk, reset                 : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        : host command handshake
//   cmd_rw, cmd_addr, cmd_data : 1=read/0=write, register address, write data
//   gain_valid, gain           : RX gain strobe and 6-bit code (latest wins)
//   spi_start, spi_word        : one-cycle launch pulse and 16-bit word
//   spi_sen_n, spi_rdata       : engine chip-enable (low = busy), readback byte
//   rd_valid, rd_addr, rd_data : readback strobe with address and byte
//   busy                       : work in flight or pending
//   err                        : sticky engine handshake timeout
module ad9866_cmdq
    import ad9866_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned GAP   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [4:0]  cmd_addr,
    input  logic [7:0]  cmd_data,
    input  logic        gain_valid,
    input  logic [5:0]  gain,
    output logic        spi_start,
    output logic [15:0] spi_word,
    input  logic        spi_sen_n,
    input  logic [7:0]  spi_rdata,
    output logic        rd_valid,
    output logic [4:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        err
);

    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [7:0] GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       cnt;
    logic [CMD_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             gain_pend;
    logic [5:0]       gain_q;
    logic             take_gain;
    logic             launch;
    logic             timeout;
    logic             tr_rw;
    logic [4:0]       tr_addr;
    logic [15:0]      launch_word;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;

    ad9866_cmdfifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   ({cmd_rw, cmd_addr, cmd_data}),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign launch_word = gain_pend
        ? pack_word(1'b0, GAIN_ADDR, {GAIN_PREFIX, gain_q})
        : pack_word(fifo_head[13], fifo_head[12:8], fifo_head[7:0]);

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        take_gain = 1'b0;
        fifo_pop  = 1'b0;
        spi_start = 1'b0;
        rd_valid  = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((gain_pend || !fifo_empty) && spi_sen_n) begin
                    state_nxt = ST_LAUNCH;
                    launch    = 1'b1;
                    take_gain = gain_pend;
                    fifo_pop  = !gain_pend;
                end
            end
            ST_LAUNCH: begin
                spi_start = 1'b1;
                state_nxt = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!spi_sen_n) begin
                    state_nxt = ST_WAIT_HIGH;
                end else if (cnt == TO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = ST_GAP;
                end
            end
            ST_WAIT_HIGH: begin
                if (spi_sen_n) begin
                    rd_valid  = tr_rw;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt >= GAP_LAST) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Readback fields are gated so they read zero outside the strobe.
    assign rd_addr = rd_valid ? tr_addr   : '0;
    assign rd_data = rd_valid ? spi_rdata : '0;
    assign busy    = (state != ST_IDLE) || !fifo_empty || gain_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            spi_word <= '0;
            tr_rw    <= 1'b0;
            tr_addr  <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) cnt <= '0;
            else if (cnt != '1)     cnt <= cnt + 1'b1;
            if (launch) begin
                spi_word <= launch_word;
                tr_rw    <= gain_pend ? 1'b0 : fifo_head[13];
                tr_addr  <= gain_pend ? GAIN_ADDR : fifo_head[12:8];
            end
            if (timeout) err <= 1'b1;
        end
    end

    // A strobe coinciding with launch of the pending gain re-arms the flag
    // with the new code, so the update is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gain_pend <= 1'b0;
            gain_q    <= '0;
        end else if (gain_valid) begin
            gain_pend <= 1'b1;
            gain_q    <= gain;
        end else if (take_gain) begin
            gain_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ad9866_cmdq.sv
module tb_ad9866_cmdq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rw = 1'b0;
    logic [4:0]  cmd_addr = '0;
    logic [7:0]  cmd_data = '0;
    logic        gain_valid = 1'b0;
    logic [5:0]  gain = '0;
    logic        spi_start;
    logic [15:0] spi_word;
    logic        spi_sen_n;
    logic [7:0]  spi_rdata = '0;
    logic        rd_valid;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        busy;
    logic        err;

    // Engine model: register file, enable driven by the transaction sequence
    // or held low by the stimulus to stall the queue.
    logic        eng_low = 1'b0;
    logic        eng_busy = 1'b0;
    int          eng_mode = 0;        // 0 = responds, 1 = never responds
    logic [15:0] eng_w;
    logic [7:0]  regs [32] = '{11: 8'h20, default: 8'h00};

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_word [$];
    logic [12:0] exp_rd   [$];
    logic [15:0] w_exp;
    logic [12:0] r_exp;

    assign spi_sen_n = ~(eng_low | eng_busy);

    always #5 clk = ~clk;

    ad9866_cmdq #(
        .DEPTH (8),
        .GAP   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rw     (cmd_rw),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .gain_valid (gain_valid),
        .gain       (gain),
        .spi_start  (spi_start),
        .spi_word   (spi_word),
        .spi_sen_n  (spi_sen_n),
        .spi_rdata  (spi_rdata),
        .rd_valid   (rd_valid),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #3;
    endtask

    always begin
        @(negedge clk);
        if (spi_start === 1'b1 && eng_mode == 0) begin
            eng_w = spi_word;
            @(negedge clk);
            eng_low = 1'b1;
            repeat (2) @(negedge clk);
            if (eng_w[15]) spi_rdata = regs[eng_w[12:8]];
            else           regs[eng_w[12:8]] = eng_w[7:0];
            eng_low = 1'b0;
        end
    end

    // Scoreboard: every launch and every readback pops the next expectation.
    always begin
        @(negedge clk);
        #3;
        if (spi_start === 1'b1) begin
            check("start_expected", 32'(exp_word.size() != 0), 32'd1);
            if (exp_word.size() != 0) begin
                w_exp = exp_word.pop_front();
                check("spi_word", 32'(spi_word), 32'(w_exp));
            end
        end
        if (rd_valid === 1'b1) begin
            check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
            if (exp_rd.size() != 0) begin
                r_exp = exp_rd.pop_front();
                check("rd_addr_data", 32'({rd_addr, rd_data}), 32'(r_exp));
            end
        end
    end

    task automatic push_cmd(input logic rw, input logic [4:0] a, input logic [7:0] d,
                            input logic [7:0] rd_exp);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        check("push_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = a;
        cmd_data  = d;
        exp_word.push_back({rw, 2'b00, a, (rw ? 8'h00 : d)});
        if (rw) exp_rd.push_back({a, rd_exp});
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(busy === 1'b0 && spi_sen_n === 1'b1) && n < 500) begin
            cyc();
            n++;
        end
        cyc();
        check(tag, 32'(busy), 32'd0);
        check({tag, "_words_done"}, 32'(exp_word.size()), 32'd0);
        check({tag, "_reads_done"}, 32'(exp_rd.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_spi_start"}, 32'(spi_start), 32'd0);
        check({tag, "_spi_word"},  32'(spi_word),  32'd0);
        check({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
        check({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
        check({tag, "_rd_data"},   32'(rd_data),   32'd0);
        check({tag, "_err"},       32'(err),       32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int n;
        int m;

        // Reset state
        repeat (3) cyc();
        check_reset_outputs("reset");
        reset = 1'b0;
        cyc();

        // Single write
        push_cmd(1'b0, 5'h07, 8'h21, 8'h00);
        wait_idle("write_idle");
        check("model_reg07", 32'(regs[7]), 32'h21);

        // Single read, model holds 0x20 at 0x0B
        push_cmd(1'b1, 5'h0B, 8'hFF, 8'h20);
        wait_idle("read_idle");

        // Fill with the engine stalled; ninth offer must be refused
        eng_busy = 1'b1;
        for (int i = 0; i < 8; i++) push_cmd(1'b0, 5'(16 + i), 8'(8'hA0 + i), 8'h00);
        check("full_ready", 32'(cmd_ready), 32'd0);
        check("full_busy",  32'(busy),      32'd1);
        cmd_valid = 1'b1;
        cmd_rw    = 1'b0;
        cmd_addr  = 5'h1F;
        cmd_data  = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("full_hold_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        eng_busy  = 1'b0;
        wait_idle("fill_idle");

        // Two gain strobes before launch: latest value wins, issued first
        eng_busy   = 1'b1;
        gain_valid = 1'b1;
        gain       = 6'h10;
        cyc();
        gain = 6'h2A;
        cyc();
        gain_valid = 1'b0;
        check("gain_busy", 32'(busy), 32'd1);
        exp_word.push_back({1'b0, 2'b00, 5'h0A, 2'b01, 6'h2A});
        push_cmd(1'b0, 5'h05, 8'h44, 8'h00);
        eng_busy = 1'b0;
        wait_idle("gain_idle");
        check("gain_model_reg0a", 32'(regs[10]), 32'h6A);

        // Engine never responds: timeout after 15 cycles in WAIT_LOW
        eng_mode = 1;
        push_cmd(1'b0, 5'h03, 8'h55, 8'h00);
        n = 0;
        while (spi_start !== 1'b1 && n < 50) begin
            cyc();
            n++;
        end
        check("to_launch_seen", 32'(spi_start), 32'd1);
        m = 0;
        do begin
            cyc();
            m++;
        end while (err !== 1'b1 && m < 40);
        check("to_cycles", 32'(m), 32'd16);
        eng_mode = 0;
        wait_idle("to_idle");
        check("to_err", 32'(err), 32'd1);
        push_cmd(1'b1, 5'h07, 8'h00, 8'h21);
        wait_idle("after_to_idle");
        check("err_sticky", 32'(err), 32'd1);

        // Reset during WAIT_HIGH of a read
        push_cmd(1'b1, 5'h0B, 8'h00, 8'h20);
        n = 0;
        while (spi_sen_n !== 1'b0 && n < 50) begin
            cyc();
            n++;
        end
        check("mid_sen_low", 32'(spi_sen_n), 32'd0);
        cyc();
        reset = 1'b1;
        exp_rd.delete();
        #1;
        check_reset_outputs("mid_reset");
        repeat (4) cyc();
        reset = 1'b0;
        repeat (3) cyc();
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_start", 32'(spi_start), 32'd0);
        check("post_reset_words", 32'(exp_word.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
